// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
// Build option: define SNAKE_WRAP_EN to wrap the head around grid edges
// instead of treating an edge crossing as a wall collision.
package snake_pkg;

   localparam int GRID_SIZE = 16;
   localparam int COORD_W   = $clog2(GRID_SIZE);
   localparam int LEN_W     = 5;

   localparam logic [COORD_W-1:0] START_X   = COORD_W'(4);
   localparam logic [COORD_W-1:0] START_Y   = COORD_W'(8);
   localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_SIZE - 1);
   localparam logic [LEN_W-1:0]   LEN_MAX   = '1;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   // Decoded joystick request: valid only for exactly one bit set.
   typedef struct packed {
      logic valid;
      dir_t dir;
   } dir_req_t;

   // Raw request bit order is {up, down, left, right}.
   function automatic dir_req_t decode_dir_req(input logic [3:0] req);
      dir_req_t r;
      r.valid = 1'b1;
      r.dir   = DIR_RIGHT;
      case (req)
         4'b1000: r.dir = DIR_UP;
         4'b0100: r.dir = DIR_DOWN;
         4'b0010: r.dir = DIR_LEFT;
         4'b0001: r.dir = DIR_RIGHT;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

   // True when b points straight back along a.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      logic r;
      r = 1'b0;
      case (a)
         DIR_UP:    r = (b == DIR_DOWN);
         DIR_DOWN:  r = (b == DIR_UP);
         DIR_LEFT:  r = (b == DIR_RIGHT);
         DIR_RIGHT: r = (b == DIR_LEFT);
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/move_tick.sv
// Move-rate divider: counts 0..TICK_DIV-1 while enabled and pulses tick_o
// combinationally during the last count, so the consumer acts on that edge.
// clear_i restarts the count from zero; a disabled divider holds its count.
module move_tick
   import snake_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int                CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_MAX);

   // Next count: clear wins, otherwise advance and wrap while enabled.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves cnt_d
      // unassigned; an unassigned path in always_comb infers a latch.
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/snake_controller.sv
// Snake game controller: IDLE/PLAY/DEAD game FSM, head position, direction
// handling, apple and collision detection, paced by the move_tick divider.
// Build option: SNAKE_WRAP_EN makes the head wrap modulo the grid size;
// without it, crossing a grid edge is a wall collision.
module snake_controller
   import snake_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000,
   parameter int INIT_LEN = 3
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [3:0]                            dir_req,
   input  logic [GRID_SIZE-1:0][GRID_SIZE-1:0]   grn_pixels,
   input  logic [COORD_W-1:0]                    apple_x,
   input  logic [COORD_W-1:0]                    apple_y,
   output logic [COORD_W-1:0]                    head_x,
   output logic [COORD_W-1:0]                    head_y,
   output logic [LEN_W-1:0]                      snake_len,
   output logic                                  step,
   output logic                                  died,
   output logic                                  apple_eaten
);

`ifdef SNAKE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   localparam logic [LEN_W-1:0] INIT_LEN_V = LEN_W'(INIT_LEN);

   state_t               state_q, state_d;
   logic [COORD_W-1:0]   head_x_q, head_x_d;
   logic [COORD_W-1:0]   head_y_q, head_y_d;
   dir_t                 dir_q, dir_d;
   dir_t                 pend_q, pend_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 step_q, step_d;
   logic                 eaten_q, eaten_d;

   logic                 tick;
   logic                 start_go;
   dir_req_t             req;
   dir_t                 ref_dir;
   logic [COORD_W-1:0]   next_x, next_y;
   logic                 at_edge;
   logic                 collision;

   // A game starts only from IDLE or DEAD; start is ignored in PLAY.
   assign start_go = start && (state_q != ST_PLAY);

   move_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_move_tick (
      .clk     (clk),
      .reset   (reset),
      .clear_i (start_go),
      .en_i    (state_q == ST_PLAY),
      .tick_o  (tick)
   );

   // Candidate head cell one step along the pending direction.
   always_comb begin
      next_x  = head_x_q;
      next_y  = head_y_q;
      at_edge = 1'b0;
      case (pend_q)
         DIR_UP: begin
            next_y  = head_y_q - COORD_W'(1);
            at_edge = (head_y_q == '0);
         end
         DIR_DOWN: begin
            next_y  = head_y_q + COORD_W'(1);
            at_edge = (head_y_q == COORD_MAX);
         end
         DIR_LEFT: begin
            next_x  = head_x_q - COORD_W'(1);
            at_edge = (head_x_q == '0);
         end
         DIR_RIGHT: begin
            next_x  = head_x_q + COORD_W'(1);
            at_edge = (head_x_q == COORD_MAX);
         end
         default: begin
            next_x  = head_x_q;
            next_y  = head_y_q;
         end
      endcase
   end

   // Power-of-two grid: the coordinate arithmetic above already wraps, so
   // the wrap build simply never reports an edge crossing as a wall.
   // The body bit is looked up on the wrapped cell; the tail cell counts.
   assign collision = (at_edge && !WRAP_EN) || grn_pixels[next_x][next_y];

   // Game FSM next state plus head, direction, length and pulse updates.
   always_comb begin
      state_d  = state_q;
      head_x_d = head_x_q;
      head_y_d = head_y_q;
      dir_d    = dir_q;
      pend_d   = pend_q;
      len_d    = len_q;
      step_d   = 1'b0;
      eaten_d  = 1'b0;

      // On a move edge the pending direction becomes current, so a request
      // arriving in that cycle is judged against the direction taking over.
      req     = decode_dir_req(dir_req);
      ref_dir = tick ? pend_q : dir_q;
      if (req.valid && !is_reverse(ref_dir, req.dir)) begin
         pend_d = req.dir;
      end

      case (state_q)
         ST_IDLE, ST_DEAD: begin
            if (start_go) begin
               state_d  = ST_PLAY;
               head_x_d = START_X;
               head_y_d = START_Y;
               dir_d    = DIR_RIGHT;
               pend_d   = DIR_RIGHT;
               len_d    = INIT_LEN_V;
            end
         end
         ST_PLAY: begin
            if (tick) begin
               if (collision) begin
                  // Collision beats apple; head stays where it was.
                  state_d = ST_DEAD;
               end else begin
                  head_x_d = next_x;
                  head_y_d = next_y;
                  dir_d    = pend_q;
                  step_d   = 1'b1;
                  if ((next_x == apple_x) && (next_y == apple_y)) begin
                     eaten_d = 1'b1;
                     len_d   = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns to IDLE start values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         head_x_q <= START_X;
         head_y_q <= START_Y;
         dir_q    <= DIR_RIGHT;
         pend_q   <= DIR_RIGHT;
         len_q    <= INIT_LEN_V;
         step_q   <= 1'b0;
         eaten_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_x_q <= head_x_d;
         head_y_q <= head_y_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         len_q    <= len_d;
         step_q   <= step_d;
         eaten_q  <= eaten_d;
      end
   end

   assign head_x      = head_x_q;
   assign head_y      = head_y_q;
   assign snake_len   = len_q;
   assign step        = step_q;
   assign apple_eaten = eaten_q;
   assign died        = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_controller.sv
// Directed bench for snake_controller with TICK_DIV=4, INIT_LEN=3.
// A per-cycle vector table covers reset, pacing and direction handling;
// hand-written sequences cover apple, self-collision and the grid edge.
module tb_snake_controller;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [3:0]           dir_req;
   logic [15:0][15:0]    grn_pixels;
   logic [3:0]           apple_x, apple_y;
   logic [3:0]           head_x, head_y;
   logic [4:0]           snake_len;
   logic                 step, died, apple_eaten;

   int total;
   int bad;

   snake_controller #(
      .TICK_DIV (4),
      .INIT_LEN (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dir_req     (dir_req),
      .grn_pixels  (grn_pixels),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .head_x      (head_x),
      .head_y      (head_y),
      .snake_len   (snake_len),
      .step        (step),
      .died        (died),
      .apple_eaten (apple_eaten)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [3:0] dir;
      logic [3:0] hx;
      logic [3:0] hy;
      logic       stp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic [3:0] d,
                      input logic [3:0] hx, input logic [3:0] hy, input logic stp);
      vec_t v;
      v.rst = r; v.st = s; v.dir = d; v.hx = hx; v.hy = hy; v.stp = stp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; dir_req = 4'b0;
      cycle();
      reset = 1'b0;
   endtask

   // Advance until a step pulse is seen, bounded to a few move periods.
   task automatic wait_step(input string name);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while ((step !== 1'b1) && (n < 20));
      check({name, " step seen"}, int'(step === 1'b1), 1);
   endtask

   task automatic check_head(input string name, input int x, input int y);
      check({name, " head_x"}, int'(head_x), x);
      check({name, " head_y"}, int'(head_y), y);
   endtask

   initial begin
      int steps_seen;
      total = 0; bad = 0;
      reset = 1'b1; start = 1'b0; dir_req = 4'b0;
      grn_pixels = '0; apple_x = 4'd0; apple_y = 4'd0;

      // ---------------- table: reset, pacing, direction rules -----------
      add(1, 0, 4'b0000, 4, 8, 0);                            // reset -> IDLE
      add(0, 0, 4'b0000, 4, 8, 0);                            // idle holds
      add(0, 1, 4'b0000, 4, 8, 0);                            // start, cnt 0
      for (int k = 0; k < 3; k++) add(0, 0, 4'b0000, 4, 8, 0);
      add(0, 0, 4'b0000, 5, 8, 1);                            // move 1
      for (int k = 0; k < 3; k++) add(0, 0, 4'b0000, 5, 8, 0);
      add(0, 0, 4'b0000, 6, 8, 1);                            // move 2
      add(0, 0, 4'b0010, 6, 8, 0);                            // left: reverse
      for (int k = 0; k < 2; k++) add(0, 0, 4'b0000, 6, 8, 0);
      add(0, 0, 4'b0000, 7, 8, 1);                            // still right
      add(0, 0, 4'b1000, 7, 8, 0);                            // up
      for (int k = 0; k < 2; k++) add(0, 0, 4'b0000, 7, 8, 0);
      add(0, 0, 4'b0000, 7, 7, 1);                            // turned up
      add(0, 0, 4'b0100, 7, 7, 0);                            // down: reverse
      add(0, 0, 4'b0011, 7, 7, 0);                            // two bits: ignored
      add(0, 0, 4'b0000, 7, 7, 0);
      add(0, 0, 4'b0000, 7, 6, 1);                            // still up
      add(0, 0, 4'b0010, 7, 6, 0);                            // left ...
      add(0, 0, 4'b0001, 7, 6, 0);                            // ... then right wins
      add(0, 0, 4'b0000, 7, 6, 0);
      add(0, 0, 4'b0000, 8, 6, 1);                            // turned right
      add(1, 0, 4'b0000, 4, 8, 0);                            // reset mid-game
      add(0, 1, 4'b0000, 4, 8, 0);                            // restart
      for (int k = 0; k < 3; k++) add(0, 0, 4'b0000, 4, 8, 0);
      add(0, 0, 4'b0000, 5, 8, 1);
      add(1, 1, 4'b0000, 4, 8, 0);                            // reset beats start
      for (int k = 0; k < 6; k++) add(0, 0, 4'b0000, 4, 8, 0); // stays idle

      foreach (vecs[i]) begin
         reset   = vecs[i].rst;
         start   = vecs[i].st;
         dir_req = vecs[i].dir;
         cycle();
         check($sformatf("v%0d head_x", i), int'(head_x), int'(vecs[i].hx));
         check($sformatf("v%0d head_y", i), int'(head_y), int'(vecs[i].hy));
         check($sformatf("v%0d step", i), int'(step), int'(vecs[i].stp));
         check($sformatf("v%0d snake_len", i), int'(snake_len), 3);
         check($sformatf("v%0d died", i), int'(died), 0);
         check($sformatf("v%0d apple_eaten", i), int'(apple_eaten), 0);
      end
      reset = 1'b0; start = 1'b0; dir_req = 4'b0;

      // ---------------- apple on the second move ----------------
      do_reset();
      apple_x = 4'd6; apple_y = 4'd8;
      start = 1'b1; cycle(); start = 1'b0;
      wait_step("apple m1");
      check_head("apple m1", 5, 8);
      check("apple m1 eaten", int'(apple_eaten), 0);
      check("apple m1 len", int'(snake_len), 3);
      wait_step("apple m2");
      check_head("apple m2", 6, 8);
      check("apple m2 eaten", int'(apple_eaten), 1);
      check("apple m2 len", int'(snake_len), 4);
      cycle();
      check("apple after eaten", int'(apple_eaten), 0);
      check("apple after step", int'(step), 0);

      // ------- self-collision on the apple cell: collision wins -------
      do_reset();
      apple_x = 4'd6; apple_y = 4'd8;
      start = 1'b1; cycle(); start = 1'b0;
      wait_step("body m1");
      check_head("body m1", 5, 8);
      grn_pixels[6][8] = 1'b1;
      cycles(4);
      check("body died", int'(died), 1);
      check_head("body frozen", 5, 8);
      check("body step", int'(step), 0);
      check("body eaten", int'(apple_eaten), 0);
      check("body len", int'(snake_len), 3);
      steps_seen = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (step === 1'b1) steps_seen++;
      end
      check("dead no steps", steps_seen, 0);
      check("dead still died", int'(died), 1);
      check_head("dead frozen", 5, 8);
      grn_pixels = '0;
      start = 1'b1; cycle(); start = 1'b0;
      check("restart died", int'(died), 0);
      check_head("restart", 4, 8);
      wait_step("restart m1");
      check_head("restart m1", 5, 8);

      // ------- right edge; start held high during PLAY is ignored -------
      do_reset();
      apple_x = 4'd0; apple_y = 4'd0;
      start = 1'b1;
      for (int i = 0; i < 11; i++) wait_step($sformatf("edge m%0d", i + 1));
      start = 1'b0;
      check_head("edge at 15", 15, 8);
      check("edge len", int'(snake_len), 3);
      cycles(4);
`ifdef SNAKE_WRAP_EN
      check("wrap died", int'(died), 0);
      check("wrap step", int'(step), 1);
      check_head("wrap", 0, 8);
`else
      check("wall died", int'(died), 1);
      check("wall step", int'(step), 0);
      check_head("wall frozen", 15, 8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
